// File: rtl/cache_control_if.sv
// Cache controller bus bundle: CPU request/response, datapath status and
// array write controls, and the backing-memory handshake.
// master: the environment side (CPU, datapath, memory).
// slave:  the cache controller.
interface cache_control_if;
    // CPU side
    logic mem_read;
    logic mem_write;
    logic mem_resp;
    // Datapath status for the current index
    logic hit;
    logic hit_way;
    logic lru_out;
    logic dirty1_out;
    logic dirty2_out;
    // Datapath array write enables
    logic load_tag1;
    logic load_tag2;
    logic load_valid1;
    logic load_valid2;
    logic load_data1;
    logic load_data2;
    logic load_dirty1;
    logic load_dirty2;
    logic load_lru;
    // Datapath write values and way select
    logic valid_in;
    logic dirty_in;
    logic lru_in;
    logic eviction;
    // Backing memory
    logic pmem_read;
    logic pmem_write;
    logic pmem_addr_sel;
    logic pmem_resp;

    modport master (
        output mem_read, mem_write, hit, hit_way, lru_out, dirty1_out, dirty2_out, pmem_resp,
        input  mem_resp, load_tag1, load_tag2, load_valid1, load_valid2, load_data1, load_data2,
        input  load_dirty1, load_dirty2, load_lru, valid_in, dirty_in, lru_in, eviction,
        input  pmem_read, pmem_write, pmem_addr_sel
    );

    modport slave (
        input  mem_read, mem_write, hit, hit_way, lru_out, dirty1_out, dirty2_out, pmem_resp,
        output mem_resp, load_tag1, load_tag2, load_valid1, load_valid2, load_data1, load_data2,
        output load_dirty1, load_dirty2, load_lru, valid_in, dirty_in, lru_in, eviction,
        output pmem_read, pmem_write, pmem_addr_sel
    );
endinterface

// File: rtl/cache_control.sv
// Two-way write-back cache controller: CHECK / WRITEBACK / FILL.
// Hits complete in the same cycle; misses evict the LRU way (writing it
// back first when dirty) and retry the access once the line is filled.
// Optional performance counters are enabled by defining CACHE_PERF_CNT_EN;
// without it the counter outputs are constant zero.
module cache_control #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    cache_control_if.slave       bus,
    output logic [CNT_WIDTH-1:0] hit_count,
    output logic [CNT_WIDTH-1:0] miss_count,
    output logic [CNT_WIDTH-1:0] wb_count
);

    typedef enum logic [1:0] {
        CHECK     = 2'd0,
        WRITEBACK = 2'd1,
        FILL      = 2'd2
    } state_t;

    state_t state;
    state_t state_next;
    logic   victim;
    logic   victim_next;
    logic   req;

    logic mem_resp_c;
    logic load_tag1_c, load_tag2_c;
    logic load_valid1_c, load_valid2_c;
    logic load_data1_c, load_data2_c;
    logic load_dirty1_c, load_dirty2_c;
    logic load_lru_c;
    logic valid_in_c, dirty_in_c, lru_in_c;
    logic eviction_c;
    logic pmem_read_c, pmem_write_c, pmem_addr_sel_c;

    // Next-state and output decode; hits respond combinationally for zero wait states
    always_comb begin
        req             = bus.mem_read | bus.mem_write;
        state_next      = state;
        victim_next     = victim;
        mem_resp_c      = 1'b0;
        load_tag1_c     = 1'b0;
        load_tag2_c     = 1'b0;
        load_valid1_c   = 1'b0;
        load_valid2_c   = 1'b0;
        load_data1_c    = 1'b0;
        load_data2_c    = 1'b0;
        load_dirty1_c   = 1'b0;
        load_dirty2_c   = 1'b0;
        load_lru_c      = 1'b0;
        valid_in_c      = 1'b0;
        dirty_in_c      = 1'b0;
        lru_in_c        = 1'b0;
        eviction_c      = 1'b0;
        pmem_read_c     = 1'b0;
        pmem_write_c    = 1'b0;
        pmem_addr_sel_c = 1'b0;
        case (state)
            CHECK: begin
                if (req) begin
                    if (bus.hit) begin
                        mem_resp_c = 1'b1;
                        load_lru_c = 1'b1;
                        lru_in_c   = ~bus.hit_way;
                        if (bus.mem_write) begin
                            dirty_in_c = 1'b1;
                            if (bus.hit_way) begin
                                load_data2_c  = 1'b1;
                                load_dirty2_c = 1'b1;
                            end else begin
                                load_data1_c  = 1'b1;
                                load_dirty1_c = 1'b1;
                            end
                        end
                    end else begin
                        victim_next = bus.lru_out;
                        if (bus.lru_out ? bus.dirty2_out : bus.dirty1_out)
                            state_next = WRITEBACK;
                        else
                            state_next = FILL;
                    end
                end
            end
            WRITEBACK: begin
                pmem_write_c    = 1'b1;
                pmem_addr_sel_c = 1'b1;
                eviction_c      = 1'b1;
                if (bus.pmem_resp)
                    state_next = req ? FILL : CHECK;
            end
            FILL: begin
                pmem_read_c = 1'b1;
                eviction_c  = 1'b1;
                if (bus.pmem_resp) begin
                    valid_in_c = 1'b1;
                    if (victim) begin
                        load_data2_c  = 1'b1;
                        load_tag2_c   = 1'b1;
                        load_valid2_c = 1'b1;
                        load_dirty2_c = 1'b1;
                    end else begin
                        load_data1_c  = 1'b1;
                        load_tag1_c   = 1'b1;
                        load_valid1_c = 1'b1;
                        load_dirty1_c = 1'b1;
                    end
                    state_next = CHECK;
                end
            end
            default: state_next = CHECK;
        endcase
    end

    // State and latched victim way; reset returns to CHECK at once
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= CHECK;
            victim <= 1'b0;
        end else begin
            state  <= state_next;
            victim <= victim_next;
        end
    end

    assign bus.mem_resp      = mem_resp_c      & reset_n;
    assign bus.load_tag1     = load_tag1_c     & reset_n;
    assign bus.load_tag2     = load_tag2_c     & reset_n;
    assign bus.load_valid1   = load_valid1_c   & reset_n;
    assign bus.load_valid2   = load_valid2_c   & reset_n;
    assign bus.load_data1    = load_data1_c    & reset_n;
    assign bus.load_data2    = load_data2_c    & reset_n;
    assign bus.load_dirty1   = load_dirty1_c   & reset_n;
    assign bus.load_dirty2   = load_dirty2_c   & reset_n;
    assign bus.load_lru      = load_lru_c      & reset_n;
    assign bus.valid_in      = valid_in_c      & reset_n;
    assign bus.dirty_in      = dirty_in_c      & reset_n;
    assign bus.lru_in        = lru_in_c        & reset_n;
    assign bus.eviction      = eviction_c      & reset_n;
    assign bus.pmem_read     = pmem_read_c     & reset_n;
    assign bus.pmem_write    = pmem_write_c    & reset_n;
    assign bus.pmem_addr_sel = pmem_addr_sel_c & reset_n;

`ifdef CACHE_PERF_CNT_EN
    logic                 retry;
    logic                 start_miss;
    logic [CNT_WIDTH-1:0] hit_q;
    logic [CNT_WIDTH-1:0] miss_q;
    logic [CNT_WIDTH-1:0] wb_q;

    assign start_miss = (state == CHECK) && (state_next != CHECK);

    // Saturating counters; retry marks the hit that finishes a miss so it is not a first-try hit
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            retry  <= 1'b0;
            hit_q  <= '0;
            miss_q <= '0;
            wb_q   <= '0;
        end else begin
            if (start_miss)
                retry <= 1'b1;
            else if ((state == CHECK) && (mem_resp_c || !req))
                retry <= 1'b0;
            if (mem_resp_c && !retry && (hit_q != '1))
                hit_q <= hit_q + CNT_WIDTH'(1);
            if (start_miss && (miss_q != '1))
                miss_q <= miss_q + CNT_WIDTH'(1);
            if ((state == WRITEBACK) && bus.pmem_resp && (wb_q != '1))
                wb_q <= wb_q + CNT_WIDTH'(1);
        end
    end

    assign hit_count  = hit_q;
    assign miss_count = miss_q;
    assign wb_count   = wb_q;
`else
    assign hit_count  = '0;
    assign miss_count = '0;
    assign wb_count   = '0;
`endif

endmodule

// File: tb/tb_cache_control.sv
// Directed testbench for cache_control (built with CNT_WIDTH=4 so that
// counter saturation is reachable). Counter expectations follow the
// CACHE_PERF_CNT_EN macro: counts when defined, constant zero otherwise.
module tb_cache_control;

`ifdef CACHE_PERF_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    localparam logic [16:0] O_RESP   = 17'd1 << 16;
    localparam logic [16:0] O_TAG1   = 17'd1 << 15;
    localparam logic [16:0] O_TAG2   = 17'd1 << 14;
    localparam logic [16:0] O_VALID1 = 17'd1 << 13;
    localparam logic [16:0] O_VALID2 = 17'd1 << 12;
    localparam logic [16:0] O_DATA1  = 17'd1 << 11;
    localparam logic [16:0] O_DATA2  = 17'd1 << 10;
    localparam logic [16:0] O_DIRTY1 = 17'd1 << 9;
    localparam logic [16:0] O_DIRTY2 = 17'd1 << 8;
    localparam logic [16:0] O_LRU    = 17'd1 << 7;
    localparam logic [16:0] O_VIN    = 17'd1 << 6;
    localparam logic [16:0] O_DIN    = 17'd1 << 5;
    localparam logic [16:0] O_LRUIN  = 17'd1 << 4;
    localparam logic [16:0] O_EVICT  = 17'd1 << 3;
    localparam logic [16:0] O_PREAD  = 17'd1 << 2;
    localparam logic [16:0] O_PWRITE = 17'd1 << 1;
    localparam logic [16:0] O_ASEL   = 17'd1;

    logic        clk;
    logic        reset_n;
    logic [3:0]  hit_count;
    logic [3:0]  miss_count;
    logic [3:0]  wb_count;
    logic [16:0] out_vec;
    logic [16:0] exp_vec;
    int          vectors;
    int          misses;
    int          exp_hit;
    int          exp_miss;
    int          exp_wb;

    cache_control_if bus ();

    cache_control #(.CNT_WIDTH(4)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .bus        (bus.slave),
        .hit_count  (hit_count),
        .miss_count (miss_count),
        .wb_count   (wb_count)
    );

    assign out_vec = {bus.mem_resp, bus.load_tag1, bus.load_tag2, bus.load_valid1, bus.load_valid2,
                      bus.load_data1, bus.load_data2, bus.load_dirty1, bus.load_dirty2, bus.load_lru,
                      bus.valid_in, bus.dirty_in, bus.lru_in, bus.eviction,
                      bus.pmem_read, bus.pmem_write, bus.pmem_addr_sel};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one cycle of inputs at the falling edge and settles before sampling
    task automatic apply_stimulus(input logic rd, input logic wr, input logic h, input logic hw,
                                  input logic lru, input logic d1, input logic d2, input logic pr);
        @(negedge clk);
        bus.mem_read   = rd;
        bus.mem_write  = wr;
        bus.hit        = h;
        bus.hit_way    = hw;
        bus.lru_out    = lru;
        bus.dirty1_out = d1;
        bus.dirty2_out = d2;
        bus.pmem_resp  = pr;
        #1;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        apply_stimulus(1, 1, 1, 1, 0, 0, 0, 1);
        vectors++;
        if (out_vec !== 17'd0) begin
            misses++;
            $display("[TB] FAIL reset_outputs: got %b expected %b", out_vec, 17'd0);
        end
        vectors++;
        if ({hit_count, miss_count, wb_count} !== 12'd0) begin
            misses++;
            $display("[TB] FAIL reset_counters: got %h expected %h", {hit_count, miss_count, wb_count}, 12'd0);
        end
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0);
        reset_n = 1'b1;
    endtask

    task automatic test_hits;
        apply_stimulus(0, 0, 1, 1, 0, 1, 1, 0);
        vectors++;
        if (out_vec !== 17'd0) begin
            misses++;
            $display("[TB] FAIL idle: got %b expected %b", out_vec, 17'd0);
        end
        apply_stimulus(1, 0, 1, 1, 0, 0, 0, 0);
        exp_vec = O_RESP | O_LRU;
        vectors++;
        if (out_vec !== exp_vec) begin
            misses++;
            $display("[TB] FAIL read_hit_way2: got %b expected %b", out_vec, exp_vec);
        end
        apply_stimulus(1, 0, 1, 0, 0, 0, 0, 0);
        exp_vec = O_RESP | O_LRU | O_LRUIN;
        vectors++;
        if (out_vec !== exp_vec) begin
            misses++;
            $display("[TB] FAIL read_hit_way1: got %b expected %b", out_vec, exp_vec);
        end
        apply_stimulus(0, 1, 1, 0, 0, 0, 0, 0);
        exp_vec = O_RESP | O_LRU | O_LRUIN | O_DATA1 | O_DIRTY1 | O_DIN;
        vectors++;
        if (out_vec !== exp_vec) begin
            misses++;
            $display("[TB] FAIL write_hit_way1: got %b expected %b", out_vec, exp_vec);
        end
        apply_stimulus(0, 1, 1, 1, 0, 0, 0, 0);
        exp_vec = O_RESP | O_LRU | O_DATA2 | O_DIRTY2 | O_DIN;
        vectors++;
        if (out_vec !== exp_vec) begin
            misses++;
            $display("[TB] FAIL write_hit_way2: got %b expected %b", out_vec, exp_vec);
        end
        apply_stimulus(1, 1, 1, 0, 0, 0, 0, 0);
        exp_vec = O_RESP | O_LRU | O_LRUIN | O_DATA1 | O_DIRTY1 | O_DIN;
        vectors++;
        if (out_vec !== exp_vec) begin
            misses++;
            $display("[TB] FAIL read_write_as_write: got %b expected %b", out_vec, exp_vec);
        end
        exp_hit = 5;
    endtask

    task automatic test_clean_miss;
        apply_stimulus(1, 0, 0, 0, 1, 1, 0, 0);
        vectors++;
        if (out_vec !== 17'd0) begin
            misses++;
            $display("[TB] FAIL clean_miss_check: got %b expected %b", out_vec, 17'd0);
        end
        exp_miss++;
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(1, 0, 0, 0, 0, 1, 1, 0);
            exp_vec = O_PREAD | O_EVICT;
            vectors++;
            if (out_vec !== exp_vec) begin
                misses++;
                $display("[TB] FAIL clean_miss_fill_wait%0d: got %b expected %b", i, out_vec, exp_vec);
            end
        end
        apply_stimulus(1, 0, 0, 0, 0, 1, 1, 1);
        exp_vec = O_PREAD | O_EVICT | O_DATA2 | O_TAG2 | O_VALID2 | O_DIRTY2 | O_VIN;
        vectors++;
        if (out_vec !== exp_vec) begin
            misses++;
            $display("[TB] FAIL clean_miss_fill_way2: got %b expected %b", out_vec, exp_vec);
        end
        apply_stimulus(1, 0, 1, 1, 0, 0, 0, 0);
        exp_vec = O_RESP | O_LRU;
        vectors++;
        if (out_vec !== exp_vec) begin
            misses++;
            $display("[TB] FAIL clean_miss_retry_hit: got %b expected %b", out_vec, exp_vec);
        end
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0);
        vectors++;
        if ({hit_count, miss_count, wb_count} !== (CNT_EN ? {4'(exp_hit), 4'(exp_miss), 4'(exp_wb)} : 12'd0)) begin
            misses++;
            $display("[TB] FAIL clean_miss_counters: got %h expected %h", {hit_count, miss_count, wb_count},
                     (CNT_EN ? {4'(exp_hit), 4'(exp_miss), 4'(exp_wb)} : 12'd0));
        end
    endtask

    task automatic test_dirty_miss;
        apply_stimulus(0, 1, 0, 0, 0, 1, 0, 0);
        vectors++;
        if (out_vec !== 17'd0) begin
            misses++;
            $display("[TB] FAIL dirty_miss_check: got %b expected %b", out_vec, 17'd0);
        end
        exp_miss++;
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(0, 1, 0, 0, 1, 1, 1, (i == 3) ? 1'b1 : 1'b0);
            exp_vec = O_PWRITE | O_ASEL | O_EVICT;
            vectors++;
            if (out_vec !== exp_vec) begin
                misses++;
                $display("[TB] FAIL dirty_miss_wb%0d: got %b expected %b", i, out_vec, exp_vec);
            end
        end
        exp_wb++;
        apply_stimulus(0, 1, 0, 0, 1, 1, 1, 0);
        exp_vec = O_PREAD | O_EVICT;
        vectors++;
        if (out_vec !== exp_vec) begin
            misses++;
            $display("[TB] FAIL dirty_miss_fill: got %b expected %b", out_vec, exp_vec);
        end
        apply_stimulus(0, 1, 0, 0, 1, 1, 1, 1);
        exp_vec = O_PREAD | O_EVICT | O_DATA1 | O_TAG1 | O_VALID1 | O_DIRTY1 | O_VIN;
        vectors++;
        if (out_vec !== exp_vec) begin
            misses++;
            $display("[TB] FAIL dirty_miss_fill_way1: got %b expected %b", out_vec, exp_vec);
        end
        apply_stimulus(0, 1, 1, 0, 1, 0, 0, 0);
        exp_vec = O_RESP | O_LRU | O_LRUIN | O_DATA1 | O_DIRTY1 | O_DIN;
        vectors++;
        if (out_vec !== exp_vec) begin
            misses++;
            $display("[TB] FAIL dirty_miss_retry_write: got %b expected %b", out_vec, exp_vec);
        end
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0);
        vectors++;
        if ({hit_count, miss_count, wb_count} !== (CNT_EN ? {4'(exp_hit), 4'(exp_miss), 4'(exp_wb)} : 12'd0)) begin
            misses++;
            $display("[TB] FAIL dirty_miss_counters: got %h expected %h", {hit_count, miss_count, wb_count},
                     (CNT_EN ? {4'(exp_hit), 4'(exp_miss), 4'(exp_wb)} : 12'd0));
        end
    endtask

    task automatic test_request_drop;
        apply_stimulus(1, 0, 0, 0, 1, 0, 1, 0);
        exp_miss++;
        apply_stimulus(1, 0, 0, 0, 1, 0, 1, 0);
        exp_vec = O_PWRITE | O_ASEL | O_EVICT;
        vectors++;
        if (out_vec !== exp_vec) begin
            misses++;
            $display("[TB] FAIL drop_wb_active: got %b expected %b", out_vec, exp_vec);
        end
        apply_stimulus(0, 0, 0, 0, 1, 0, 1, 1);
        vectors++;
        if (out_vec !== exp_vec) begin
            misses++;
            $display("[TB] FAIL drop_wb_finish: got %b expected %b", out_vec, exp_vec);
        end
        exp_wb++;
        apply_stimulus(0, 0, 1, 0, 1, 0, 1, 0);
        vectors++;
        if (out_vec !== 17'd0) begin
            misses++;
            $display("[TB] FAIL drop_back_to_check: got %b expected %b", out_vec, 17'd0);
        end
    endtask

    task automatic test_stray_pmem_resp;
        apply_stimulus(0, 0, 0, 0, 0, 1, 1, 1);
        vectors++;
        if (out_vec !== 17'd0) begin
            misses++;
            $display("[TB] FAIL stray_resp_cycle: got %b expected %b", out_vec, 17'd0);
        end
        apply_stimulus(0, 0, 0, 0, 0, 1, 1, 0);
        vectors++;
        if (out_vec !== 17'd0) begin
            misses++;
            $display("[TB] FAIL stray_resp_after: got %b expected %b", out_vec, 17'd0);
        end
        vectors++;
        if ({hit_count, miss_count, wb_count} !== (CNT_EN ? {4'(exp_hit), 4'(exp_miss), 4'(exp_wb)} : 12'd0)) begin
            misses++;
            $display("[TB] FAIL stray_resp_counters: got %h expected %h", {hit_count, miss_count, wb_count},
                     (CNT_EN ? {4'(exp_hit), 4'(exp_miss), 4'(exp_wb)} : 12'd0));
        end
    endtask

    task automatic test_mid_fill_reset;
        apply_stimulus(1, 0, 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            apply_stimulus(1, 0, 0, 0, 1, 0, 0, 0);
            exp_vec = O_PREAD | O_EVICT;
            vectors++;
            if (out_vec !== exp_vec) begin
                misses++;
                $display("[TB] FAIL midreset_fill%0d: got %b expected %b", i, out_vec, exp_vec);
            end
        end
        @(negedge clk);
        reset_n  = 1'b0;
        bus.hit  = 1'b1;
        bus.hit_way = 1'b1;
        #1;
        vectors++;
        if (out_vec !== 17'd0) begin
            misses++;
            $display("[TB] FAIL midreset_outputs: got %b expected %b", out_vec, 17'd0);
        end
        vectors++;
        if ({hit_count, miss_count, wb_count} !== 12'd0) begin
            misses++;
            $display("[TB] FAIL midreset_counters: got %h expected %h", {hit_count, miss_count, wb_count}, 12'd0);
        end
        exp_hit  = 0;
        exp_miss = 0;
        exp_wb   = 0;
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        exp_vec = O_RESP | O_LRU;
        vectors++;
        if (out_vec !== exp_vec) begin
            misses++;
            $display("[TB] FAIL midreset_first_hit: got %b expected %b", out_vec, exp_vec);
        end
        exp_hit = 1;
    endtask

    task automatic test_saturation;
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(1, 0, 1, 0, 0, 0, 0, 0);
        end
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0);
        exp_hit = 6;
        vectors++;
        if (hit_count !== (CNT_EN ? 4'(exp_hit) : 4'd0)) begin
            misses++;
            $display("[TB] FAIL hit_count_partial: got %h expected %h", hit_count, (CNT_EN ? 4'(exp_hit) : 4'd0));
        end
        for (int i = 0; i < 20; i++) begin
            apply_stimulus(1, 0, 1, 0, 0, 0, 0, 0);
        end
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0);
        vectors++;
        if (hit_count !== (CNT_EN ? 4'hF : 4'd0)) begin
            misses++;
            $display("[TB] FAIL hit_count_saturate: got %h expected %h", hit_count, (CNT_EN ? 4'hF : 4'd0));
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vectors  = 0;
        misses   = 0;
        exp_hit  = 0;
        exp_miss = 0;
        exp_wb   = 0;
        reset_n  = 1'b0;
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.hit        = 1'b0;
        bus.hit_way    = 1'b0;
        bus.lru_out    = 1'b0;
        bus.dirty1_out = 1'b0;
        bus.dirty2_out = 1'b0;
        bus.pmem_resp  = 1'b0;
        test_reset();
        test_hits();
        test_clean_miss();
        test_dirty_miss();
        test_request_drop();
        test_stray_pmem_resp();
        test_mid_fill_reset();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
        $finish;
    end

endmodule
